// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: buffers scan-code bytes in a FIFO and sends 11-bit frames on open-collector enables.
// Define PS2_INHIBIT_EN to honour host clock inhibit (abort + retransmit); otherwise ps2_clk_in is ignored.
//
// state     | meaning
// S_IDLE    | enables released, waiting for a queued byte (and, with inhibit, a high clock)
// S_HIGH    | clock released, current bit presented on the data enable
// S_LOW     | clock driven low, data held
// S_GAP     | enables released, inter-frame spacing
// S_INHIBIT | frame abandoned, waiting for the host to release the clock for GAP cycles
module ps2_device_tx #(
  parameter int DEPTH    = 8,
  parameter int CLK_HALF = 2500,
  parameter int GAP      = 5000
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  input  logic                   key_action,
  input  logic [7:0]             scan_code,
  input  logic                   ps2_clk_in,
  output logic                   ps2_clk_oe,
  output logic                   ps2_dat_oe,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   frame_done,
  output logic                   aborted
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_HALF - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP,
    S_INHIBIT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_idx;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          done_now;
  logic          clk_sync;
  logic          start_ok;
  logic          inhibit_now;

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    case (idx)
      4'd0:    v = 1'b0;
      4'd9:    v = ~(^b);
      4'd10:   v = 1'b1;
      default: v = b[3'(idx - 4'd1)];
    endcase
    return v;
  endfunction

  assign ready      = (count != FULL);
  assign fifo_count = count;
  assign push       = key_action & ready;
  assign head       = mem[rd_ptr];
  assign done_now   = (state == S_LOW) && (timer == '0) && (bit_idx == 4'd10);
  assign pop        = done_now;

`ifdef PS2_INHIBIT_EN
  logic [1:0] clk_meta;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) clk_meta <= 2'b11;
    else         clk_meta <= {clk_meta[0], ps2_clk_in};
  end

  assign clk_sync    = clk_meta[1];
  assign start_ok    = clk_sync;
  assign inhibit_now = (bit_idx <= 4'd9) & ~clk_sync;
`else
  logic unused_clk_in;

  assign unused_clk_in = ps2_clk_in;
  assign clk_sync      = 1'b1;
  assign start_ok      = 1'b1;
  assign inhibit_now   = 1'b0;
`endif

  // Storage carries no reset; validity is tracked by count and the pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= scan_code;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (key_action && !ready) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if ((count != '0) && start_ok) begin
            bit_idx    <= 4'd0;
            timer      <= HALF_LOAD;
            ps2_dat_oe <= ~frame_bit(head, 4'd0);
            state      <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (timer == '0) begin
            if (inhibit_now) begin
              aborted    <= 1'b1;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              timer      <= GAP_LOAD;
              state      <= S_INHIBIT;
            end else begin
              ps2_clk_oe <= 1'b1;
              timer      <= HALF_LOAD;
              state      <= S_LOW;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_LOW: begin
          if (timer == '0) begin
            if (bit_idx < 4'd10) begin
              bit_idx    <= bit_idx + 4'd1;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= ~frame_bit(head, bit_idx + 4'd1);
              timer      <= HALF_LOAD;
              state      <= S_HIGH;
            end else begin
              frame_done <= 1'b1;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              timer      <= GAP_LOAD;
              state      <= S_GAP;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (timer == '0) state <= S_IDLE;
          else             timer <= timer - TW'(1);
        end
        S_INHIBIT: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          // Any low sample restarts the release window.
          if (!clk_sync)          timer <= GAP_LOAD;
          else if (timer == '0)   state <= S_IDLE;
          else                    timer <= timer - TW'(1);
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: queue-based reference model plus a line-level frame monitor.
// Host-inhibit scenarios run only when PS2_INHIBIT_EN is defined.
`timescale 1ns/1ps
module tb_ps2_device_tx;
  localparam int DEPTH = 4;
  localparam int CH    = 4;
  localparam int GP    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_action = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       host_hold = 1'b0;
  logic       ps2_clk_in;
  logic       clk_oe, dat_oe, ready, overflow, frame_done, aborted;
  logic [2:0] fifo_count;

  // Pulled-up clock net: low if either side drives it.
  assign ps2_clk_in = ~(clk_oe | host_hold);

  ps2_device_tx #(.DEPTH(DEPTH), .CLK_HALF(CH), .GAP(GP)) dut (
    .CLOCK_50  (clk),
    .Resetn    (rst_n),
    .key_action(key_action),
    .scan_code (scan_code),
    .ps2_clk_in(ps2_clk_in),
    .ps2_clk_oe(clk_oe),
    .ps2_dat_oe(dat_oe),
    .ready     (ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_done(frame_done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  // Reference model state
  logic [7:0]  q[$];
  logic        exp_ovf = 1'b0;
  int          bitcnt = 0;
  logic [10:0] rx = '0;
  logic        in_frame = 1'b0;
  logic        expect_gap = 1'b0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          frames = 0;
  int          aborts = 0;
  logic        prev_clk_oe = 1'b0;
  logic        prev_dat_oe = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) begin
        check_val("done_bits", bitcnt, 11);
        check_val("frame_len", cyc - start_cyc, 22 * CH);
        check_val("pop_pending", q.size() > 0, 1);
        if (q.size() > 0) void'(q.pop_front());
        frames++;
        in_frame   = 1'b0;
        bitcnt     = 0;
        expect_gap = (q.size() > 0);
        done_cyc   = cyc;
      end
      if (aborted) begin
        check_val("abort_clk_oe", clk_oe, 0);
        check_val("abort_dat_oe", dat_oe, 0);
        aborts++;
        in_frame   = 1'b0;
        bitcnt     = 0;
        expect_gap = 1'b0;
      end
      if (!in_frame && dat_oe && !prev_dat_oe) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
        if (expect_gap) check_val("frame_gap", cyc - done_cyc, GP + 1);
        expect_gap = 1'b0;
      end
      if (clk_oe && !prev_clk_oe) begin
        if (bitcnt < 11) rx[bitcnt] = ~dat_oe;
        bitcnt++;
        if (bitcnt == 11) begin
          check_val("frame_pending", q.size() > 0, 1);
          if (q.size() > 0) check_val("frame_bits", rx, exp_frame(q[0]));
        end
      end
      check_val("fifo_count", fifo_count, q.size());
      check_val("ready", ready, q.size() < DEPTH);
      check_val("overflow", overflow, exp_ovf);
    end
    prev_clk_oe = clk_oe;
    prev_dat_oe = dat_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    key_action = 1'b1;
    scan_code  = b;
    @(posedge clk);
    if (q.size() < DEPTH) q.push_back(b);
    else                  exp_ovf = 1'b1;
    #1 key_action = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_in_time", n < budget, 1);
    tick(GP + 3);
  endtask

  int f0;
  int a0;
  int k;
  int rel_cyc;
  logic seen;

  initial begin
    // Reset state
    tick(3);
    @(negedge clk);
    check_val("rst_clk_oe", clk_oe, 0);
    check_val("rst_dat_oe", dat_oe, 0);
    check_val("rst_ready", ready, 1);
    check_val("rst_count", fifo_count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_aborted", aborted, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(3);

    // Single byte with start latency
    f0 = frames;
    push(8'h1C);
    @(negedge clk);
    check_val("lat_first", dat_oe, 0);
    @(negedge clk);
    check_val("lat_start", dat_oe, 1);
    @(posedge clk); #1;
    drain(400);
    check_val("single_frames", frames - f0, 1);

    // Queued pair
    f0 = frames;
    push(8'hF0);
    push(8'h1C);
    drain(600);
    check_val("pair_frames", frames - f0, 2);

    // Overflow
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      push(8'h30 + 8'(i));
      if (i == 3) begin
        @(negedge clk);
        check_val("ovf_ready_low", ready, 0);
        @(posedge clk); #1;
      end
    end
    check_val("ovf_flag", overflow, 1);
    drain(1000);
    check_val("ovf_frames", frames - f0, 4);

    // Randomized bursts
    for (int r = 0; r < 10; r++) begin
      f0 = frames;
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        push(8'($urandom));
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 60));
      end
      drain(1200);
      check_val("rand_any_frame", frames > f0, 1);
    end

    // Reset mid-frame (during bit 3 low phase)
    push(8'h00);
    tick(30);
    check_val("pre_rst_clk_oe", clk_oe, 1);
    check_val("pre_rst_dat_oe", dat_oe, 1);
    #1 rst_n = 1'b0;
    q.delete();
    exp_ovf    = 1'b0;
    in_frame   = 1'b0;
    bitcnt     = 0;
    expect_gap = 1'b0;
    #1;
    check_val("midrst_clk_oe", clk_oe, 0);
    check_val("midrst_dat_oe", dat_oe, 0);
    check_val("midrst_count", fifo_count, 0);
    check_val("midrst_ready", ready, 1);
    check_val("midrst_overflow", overflow, 0);
    tick(2);
    rst_n = 1'b1;
    f0 = frames;
    tick(150);
    check_val("post_rst_idle", in_frame, 0);
    check_val("post_rst_frames", frames - f0, 0);

`ifdef PS2_INHIBIT_EN
    // Host inhibit during bit 5
    f0 = frames;
    a0 = aborts;
    push(8'h5A);
    tick(41);
    host_hold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (aborted) seen = 1'b1;
    end
    check_val("abort_seen", seen, 1);
    @(posedge clk); #1;
    tick(20);
    check_val("inhibit_quiet", dat_oe | clk_oe, 0);
    check_val("inhibit_count", fifo_count, 1);
    host_hold = 1'b0;
    rel_cyc = cyc;
    drain(600);
    check_val("retx_delay", (start_cyc - rel_cyc) >= GP, 1);
    check_val("retx_frames", frames - f0, 1);
    check_val("retx_aborts", aborts - a0, 1);

    // Idle inhibit
    f0 = frames;
    host_hold = 1'b1;
    tick(3);
    push(8'h29);
    tick(30);
    check_val("idle_inhibit_dat", dat_oe, 0);
    check_val("idle_inhibit_frame", in_frame, 0);
    host_hold = 1'b0;
    drain(600);
    check_val("idle_inhibit_sent", frames - f0, 1);
`else
    // Clock input ignored without inhibit support
    f0 = frames;
    a0 = aborts;
    host_hold = 1'b1;
    push(8'h29);
    drain(600);
    host_hold = 1'b0;
    check_val("noinh_frames", frames - f0, 1);
    check_val("noinh_aborts", aborts - a0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
